// File: rtl/hd63701_timer.sv
// HD63701 programmable timer: free-running counter, output compare, TCSR and IRQ2 generation.
// Input capture (synchronizer, ICR, ICF/EICI) is present only when HD63701_TIMER_ICAP_EN is defined.
module hd63701_timer #(
   parameter logic [15:0] BASE = 16'h0008
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] AD,
   input  logic        RW,
   input  logic [7:0]  DO,
   output logic [7:0]  RDATA,
   output logic        RSEL,
   input  logic        TIN,
   output logic        TOUT,
   output logic        IRQ2,
   output logic [3:0]  IRQ2V
);

   localparam logic [2:0] A_TCSR   = 3'd0;
   localparam logic [2:0] A_FRC_HI = 3'd1;
   localparam logic [2:0] A_FRC_LO = 3'd2;
   localparam logic [2:0] A_OCR_HI = 3'd3;
   localparam logic [2:0] A_OCR_LO = 3'd4;
   localparam logic [2:0] A_ICR_HI = 3'd5;
   localparam logic [2:0] A_ICR_LO = 3'd6;

   // Returns {flag, arm}: a set beats a clear, and a clear always drops the arm bit.
   function automatic logic [1:0] flag_step(input logic flag, input logic arm, input logic set,
                                            input logic clr_req, input logic arm_req);
      logic       clr;
      logic [1:0] r;
      clr = arm & clr_req;
      if (set) begin
         r[1] = 1'b1;
      end else if (clr) begin
         r[1] = 1'b0;
      end else begin
         r[1] = flag;
      end
      if (clr) begin
         r[0] = 1'b0;
      end else if (arm_req) begin
         r[0] = flag;
      end else begin
         r[0] = arm;
      end
      return r;
   endfunction

   logic [15:0] off_s;
   logic [2:0]  reg_sel;
   logic        wr_en, rd_en;
   logic        rd_tcsr, rd_frc_hi, rd_icr_hi;
   logic        wr_tcsr, wr_frc_hi, wr_frc_lo, wr_ocr_hi, wr_ocr_lo;
   logic        tof_set, ocf_set, icf_set;
   logic [15:0] icr_view;
   logic [7:0]  icbuf_view;
   logic [7:0]  rdata_s;

   logic [15:0] frc_q, frc_d;
   logic [15:0] ocr_q, ocr_d;
   logic [4:0]  ctl_q, ctl_d;
   logic        icf_q, icf_d, ocf_q, ocf_d, tof_q, tof_d;
   logic        arm_icf_q, arm_icf_d, arm_ocf_q, arm_ocf_d, arm_tof_q, arm_tof_d;
   logic [7:0]  rbuf_q, rbuf_d, wbuf_q, wbuf_d;
   logic        inhibit_q, inhibit_d;
   logic        tout_q, tout_d;
   logic        irq2_q, irq2_d;
   logic [3:0]  irq2v_q, irq2v_d;

   // Unsigned offset makes addresses below BASE wrap high and fall outside the window.
   assign off_s   = AD - BASE;
   assign RSEL    = (off_s < 16'd7);
   assign reg_sel = off_s[2:0];
   assign wr_en   = RSEL & ~RW;
   assign rd_en   = RSEL & RW;

   assign rd_tcsr   = rd_en & (reg_sel == A_TCSR);
   assign rd_frc_hi = rd_en & (reg_sel == A_FRC_HI);
   assign rd_icr_hi = rd_en & (reg_sel == A_ICR_HI);
   assign wr_tcsr   = wr_en & (reg_sel == A_TCSR);
   assign wr_frc_hi = wr_en & (reg_sel == A_FRC_HI);
   assign wr_frc_lo = wr_en & (reg_sel == A_FRC_LO);
   assign wr_ocr_hi = wr_en & (reg_sel == A_OCR_HI);
   assign wr_ocr_lo = wr_en & (reg_sel == A_OCR_LO);

   assign tof_set = (frc_q == 16'hFFFF) & ~wr_frc_lo;
   assign ocf_set = (frc_q == ocr_q) & ~inhibit_q;

`ifdef HD63701_TIMER_ICAP_EN
   logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [15:0] icr_q, icr_d;
   logic [7:0]  icbuf_q, icbuf_d;
   logic        cap_edge;

   // TIN synchronizer, IEDG-selected edge detect and ICR capture.
   always_comb begin
      sync1_d = TIN;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      if (ctl_q[1]) begin
         cap_edge = sync2_q & ~sync3_q;
      end else begin
         cap_edge = ~sync2_q & sync3_q;
      end
      if (cap_edge) begin
         icr_d = frc_q;
      end else begin
         icr_d = icr_q;
      end
      if (rd_icr_hi) begin
         icbuf_d = icr_q[7:0];
      end else begin
         icbuf_d = icbuf_q;
      end
   end

   // Capture-path state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         icr_q   <= 16'h0000;
         icbuf_q <= 8'h00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         icr_q   <= icr_d;
         icbuf_q <= icbuf_d;
      end
   end

   assign icf_set    = cap_edge;
   assign icr_view   = icr_q;
   assign icbuf_view = icbuf_q;
`else
   logic icap_unused;
   assign icap_unused = TIN ^ DO[4];
   assign icf_set     = 1'b0;
   assign icr_view    = 16'h0000;
   assign icbuf_view  = 8'h00;
`endif

   // Counter, compare, control register, buffers, flags and interrupt next state.
   always_comb begin
      if (wr_frc_lo) begin
         frc_d = {wbuf_q, DO};
      end else begin
         frc_d = frc_q + 16'd1;
      end
      if (wr_frc_hi) begin
         wbuf_d = DO;
      end else begin
         wbuf_d = wbuf_q;
      end
      if (rd_frc_hi) begin
         rbuf_d = frc_q[7:0];
      end else begin
         rbuf_d = rbuf_q;
      end
      ocr_d = ocr_q;
      if (wr_ocr_hi) begin
         ocr_d[15:8] = DO;
      end else if (wr_ocr_lo) begin
         ocr_d[7:0] = DO;
      end else begin
         ocr_d = ocr_q;
      end
      inhibit_d = wr_ocr_hi | wr_ocr_lo;
      if (wr_tcsr) begin
`ifdef HD63701_TIMER_ICAP_EN
         ctl_d = DO[4:0];
`else
         ctl_d = {1'b0, DO[3:0]};
`endif
      end else begin
         ctl_d = ctl_q;
      end
      if (ocf_set) begin
         tout_d = ctl_q[0];
      end else begin
         tout_d = tout_q;
      end
      {icf_d, arm_icf_d} = flag_step(icf_q, arm_icf_q, icf_set, rd_icr_hi, rd_tcsr);
      {ocf_d, arm_ocf_d} = flag_step(ocf_q, arm_ocf_q, ocf_set, wr_ocr_hi | wr_ocr_lo, rd_tcsr);
      {tof_d, arm_tof_d} = flag_step(tof_q, arm_tof_q, tof_set, rd_frc_hi, rd_tcsr);
      irq2v_d = {1'b0, tof_q & ctl_q[2], ocf_q & ctl_q[3], icf_q & ctl_q[4]};
      irq2_d  = |irq2v_d;
   end

   // Main register bank with synchronous reset; a reset edge discards any bus access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frc_q     <= 16'h0000;
         ocr_q     <= 16'hFFFF;
         ctl_q     <= 5'd0;
         icf_q     <= 1'b0;
         ocf_q     <= 1'b0;
         tof_q     <= 1'b0;
         arm_icf_q <= 1'b0;
         arm_ocf_q <= 1'b0;
         arm_tof_q <= 1'b0;
         rbuf_q    <= 8'h00;
         wbuf_q    <= 8'h00;
         inhibit_q <= 1'b0;
         tout_q    <= 1'b0;
         irq2_q    <= 1'b0;
         irq2v_q   <= 4'd0;
      end else begin
         frc_q     <= frc_d;
         ocr_q     <= ocr_d;
         ctl_q     <= ctl_d;
         icf_q     <= icf_d;
         ocf_q     <= ocf_d;
         tof_q     <= tof_d;
         arm_icf_q <= arm_icf_d;
         arm_ocf_q <= arm_ocf_d;
         arm_tof_q <= arm_tof_d;
         rbuf_q    <= rbuf_d;
         wbuf_q    <= wbuf_d;
         inhibit_q <= inhibit_d;
         tout_q    <= tout_d;
         irq2_q    <= irq2_d;
         irq2v_q   <= irq2v_d;
      end
   end

   // Read-data mux, combinational from AD.
   always_comb begin
      if (RSEL) begin
         case (reg_sel)
            A_TCSR:   rdata_s = {icf_q, ocf_q, tof_q, ctl_q};
            A_FRC_HI: rdata_s = frc_q[15:8];
            A_FRC_LO: rdata_s = rbuf_q;
            A_OCR_HI: rdata_s = ocr_q[15:8];
            A_OCR_LO: rdata_s = ocr_q[7:0];
            A_ICR_HI: rdata_s = icr_view[15:8];
            A_ICR_LO: rdata_s = icbuf_view;
            default:  rdata_s = 8'h00;
         endcase
      end else begin
         rdata_s = 8'h00;
      end
   end

   assign RDATA = rdata_s;
   assign TOUT  = tout_q;
   assign IRQ2  = irq2_q;
   assign IRQ2V = irq2v_q;

endmodule

// File: tb/tb_hd63701_timer.sv
// Directed bench for hd63701_timer: expected values are queued when a step is driven and
// popped when the DUT output is sampled. Capture checks follow HD63701_TIMER_ICAP_EN.
module tb_hd63701_timer;

   localparam logic [15:0] BASE    = 16'h0008;
   localparam logic [15:0] IDLE_AD = 16'h0100;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] AD  = IDLE_AD;
   logic        RW  = 1'b1;
   logic [7:0]  DO  = 8'h00;
   logic        TIN = 1'b0;
   logic [7:0]  RDATA;
   logic        RSEL;
   logic        TOUT;
   logic        IRQ2;
   logic [3:0]  IRQ2V;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] frc_m = 16'h0000;
   logic [7:0]  wbuf_m = 8'h00;
   logic [15:0] cap_m;

   hd63701_timer #(.BASE(BASE)) dut (
      .CLK(CLK), .RST(RST), .AD(AD), .RW(RW), .DO(DO),
      .RDATA(RDATA), .RSEL(RSEL), .TIN(TIN), .TOUT(TOUT),
      .IRQ2(IRQ2), .IRQ2V(IRQ2V)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
      push_exp(e);
      check(tag, obs);
   endtask

   // One clock; the counter model advances with it.
   task automatic tick();
      @(posedge CLK);
      #1;
      frc_m = frc_m + 16'd1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d);
      AD = BASE + {13'd0, off};
      RW = 1'b0;
      DO = d;
      tick();
      if (off == 3'd1) wbuf_m = d;
      if (off == 3'd2) frc_m = {wbuf_m, d};
      AD = IDLE_AD;
      RW = 1'b1;
      DO = 8'h00;
   endtask

   task automatic rd(input logic [2:0] off, input logic [7:0] e, input string tag);
      AD = BASE + {13'd0, off};
      RW = 1'b1;
      push_exp({8'h00, e});
      #1;
      check(tag, {8'h00, RDATA});
      tick();
      AD = IDLE_AD;
   endtask

   // FRC hi then lo after 'gap' idle cycles; lo must return the byte latched by hi.
   task automatic rd_frc(input int gap, input string tag);
      logic [15:0] snap;
      snap = frc_m;
      rd(3'd1, snap[15:8], {tag, "_hi"});
      idle(gap);
      rd(3'd2, snap[7:0], {tag, "_lo"});
   endtask

   task automatic wait_frc(input logic [15:0] target, input int budget);
      int k;
      k = 0;
      while (frc_m != target && k < budget) begin
         tick();
         k++;
      end
      if (frc_m != target) begin
         n_checks++;
         n_fail++;
         $error("FAIL wait_frc observed=%h expected=%h", frc_m, target);
      end
   endtask

   initial begin
      // Reset and decode window.
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      frc_m = 16'h0000;
      chk("rst_tout", {15'd0, TOUT}, 16'h0000);
      chk("rst_irq2", {15'd0, IRQ2}, 16'h0000);
      chk("rst_irq2v", {12'd0, IRQ2V}, 16'h0000);
      chk("rsel_idle", {15'd0, RSEL}, 16'h0000);
      AD = BASE + 16'd7;
      #1;
      chk("rsel_base7", {15'd0, RSEL}, 16'h0000);
      chk("rdata_unmapped", {8'h00, RDATA}, 16'h0000);
      AD = BASE + 16'd6;
      #1;
      chk("rsel_base6", {15'd0, RSEL}, 16'h0001);
      AD = BASE - 16'd1;
      #1;
      chk("rsel_below", {15'd0, RSEL}, 16'h0000);
      AD = IDLE_AD;
      rd(3'd0, 8'h00, "rst_tcsr");
      rd(3'd3, 8'hFF, "rst_ocr_hi");
      rd(3'd4, 8'hFF, "rst_ocr_lo");
      rd(3'd5, 8'h00, "rst_icr_hi");
      rd(3'd6, 8'h00, "rst_icr_lo");
      rd_frc(0, "frc_count");

      // Full 16-bit wrap: TOF, and OCF because OCR still holds FFFF.
      wr(3'd0, 8'h04);
      wait_frc(16'hFFFF, 70000);
      chk("pre_wrap_irq2v", {12'd0, IRQ2V}, 16'h0000);
      tick();
      chk("wrap_irq2_lag", {15'd0, IRQ2}, 16'h0000);
      tick();
      chk("wrap_irq2", {15'd0, IRQ2}, 16'h0001);
      chk("wrap_irq2v", {12'd0, IRQ2V}, 16'h0004);
      rd(3'd0, 8'h64, "wrap_tcsr");
      rd_frc(0, "tof_clear_read");
      rd(3'd0, 8'h44, "tof_cleared_tcsr");
      chk("tof_cleared_irq2", {15'd0, IRQ2}, 16'h0000);

      // Output compare at 0x0100 with EOCI and OLVL=1.
      wr(3'd3, 8'h01);
      wr(3'd4, 8'h00);
      wr(3'd0, 8'h09);
      rd(3'd0, 8'h09, "ocf_cleared_tcsr");
      wr(3'd1, 8'h00);
      wr(3'd2, 8'hF8);
      wait_frc(16'h0100, 64);
      chk("pre_cmp_tout", {15'd0, TOUT}, 16'h0000);
      tick();
      chk("cmp_tout", {15'd0, TOUT}, 16'h0001);
      chk("cmp_irq2v_lag", {12'd0, IRQ2V}, 16'h0000);
      tick();
      chk("cmp_irq2v", {12'd0, IRQ2V}, 16'h0002);
      chk("cmp_irq2", {15'd0, IRQ2}, 16'h0001);

      // OCR write without a prior TCSR read must not clear OCF.
      wr(3'd4, 8'h00);
      rd(3'd0, 8'h49, "ocf_unarmed_tcsr");
      wr(3'd3, 8'h01);
      rd(3'd0, 8'h09, "ocf_armed_clear");
      chk("tout_hold", {15'd0, TOUT}, 16'h0001);

      // Compare is blocked in the cycle right after an OCR write.
      wr(3'd1, 8'h03);
      wr(3'd2, 8'h00);
      wr(3'd3, 8'h03);
      wr(3'd4, 8'h02);
      idle(2);
      rd(3'd0, 8'h09, "cmp_inhibit");

      // TOF set in the same cycle as its armed clear: set wins, arm drops.
      wr(3'd1, 8'hFF);
      wr(3'd2, 8'hFD);
      wait_frc(16'hFFFF, 8);
      tick();
      rd(3'd0, 8'h29, "tof_set_tcsr");
      wr(3'd1, 8'hFF);
      wr(3'd2, 8'hFE);
      tick();
      rd_frc(0, "tof_race");
      rd_frc(0, "tof_disarmed");
      rd(3'd0, 8'h29, "tof_race_tcsr");
      rd_frc(0, "tof_clear2");
      rd(3'd0, 8'h09, "tof_clear2_tcsr");

`ifdef HD63701_TIMER_ICAP_EN
      // Rising-edge capture; TIN reaches ICR three clocks after it moves.
      wr(3'd0, 8'h12);
      wr(3'd1, 8'h12);
      wr(3'd2, 8'h30);
      wait_frc(16'h1232, 8);
      TIN = 1'b1;
      idle(2);
      rd(3'd0, 8'h12, "cap_latency");
      rd(3'd0, 8'h92, "cap_tcsr");
      chk("cap_irq2v", {12'd0, IRQ2V}, 16'h0001);
      chk("cap_irq2", {15'd0, IRQ2}, 16'h0001);
      rd(3'd5, 8'h12, "cap_icr_hi");
      rd(3'd6, 8'h34, "cap_icr_lo");
      chk("icf_clr_irq2", {15'd0, IRQ2}, 16'h0000);
      chk("icf_clr_irq2v", {12'd0, IRQ2V}, 16'h0000);
      rd(3'd0, 8'h12, "icf_clr_tcsr");
      TIN = 1'b0;
      idle(5);
      rd(3'd0, 8'h12, "no_cap_falling");
      wr(3'd0, 8'h10);
      TIN = 1'b1;
      idle(4);
      rd(3'd0, 8'h10, "no_cap_rising");
      cap_m = frc_m + 16'd2;
      TIN = 1'b0;
      idle(4);
      rd(3'd0, 8'h90, "cap_fall_tcsr");
      rd(3'd5, cap_m[15:8], "cap_fall_hi");
      rd(3'd6, cap_m[7:0], "cap_fall_lo");
`else
      // Capture absent: TIN ignored, ICR reads zero, ICF/EICI read zero.
      wr(3'd0, 8'h12);
      TIN = 1'b1;
      idle(4);
      TIN = 1'b0;
      idle(4);
      rd(3'd0, 8'h02, "nocap_tcsr");
      rd(3'd5, 8'h00, "nocap_icr_hi");
      rd(3'd6, 8'h00, "nocap_icr_lo");
      chk("nocap_irq2v", {12'd0, IRQ2V}, 16'h0000);
`endif

      // Reset during a TCSR write discards the write; counting restarts at 0001.
      AD = BASE;
      RW = 1'b0;
      DO = 8'h1F;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      AD = IDLE_AD;
      RW = 1'b1;
      DO = 8'h00;
      frc_m = 16'h0000;
      wbuf_m = 8'h00;
      chk("rst2_tout", {15'd0, TOUT}, 16'h0000);
      tick();
      rd_frc(0, "rst2_first_count");
      rd(3'd0, 8'h00, "rst2_tcsr");
      rd(3'd3, 8'hFF, "rst2_ocr_hi");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
